// File: rtl/m2_wb_arbiter_pkg.sv
// Shared types and defaults for the two-master m2 Wishbone arbiter.
package m2_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_BL_W = 10;

endpackage

// File: rtl/m2_wb_arbiter_if.sv
// Wishbone port with burst length and last-ack; master drives request, slave drives response.
interface m2_wb_arbiter_if #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BLW = 10
) ();

    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic [BLW-1:0]  bl;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            lack;
    logic            err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, bl,
        input  dat_r, ack, lack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, bl,
        output dat_r, ack, lack, err
    );

endinterface

// File: rtl/m2_wb_arbiter_rr_arb2.sv
// Two-way request picker: round-robin on last grant, or fixed M0 priority.
module m2_wb_arbiter_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    // last_gnt = 1 means M1 was served last, so M0 wins a tie.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (rr_en && !last_gnt) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/m2_wb_arbiter.sv
// Arbitrates the core "others" master (M0) and the D$ refill master (M1) onto the
// SoC m2 port, holding the grant for a whole burst.
module m2_wb_arbiter
    import m2_wb_arbiter_pkg::*;
#(
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW,
    parameter int BLW   = WB_BL_W,
    parameter bit RR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    m2_wb_arbiter_if.slave  m0,
    m2_wb_arbiter_if.slave  m1,
    m2_wb_arbiter_if.master m2_wbd,
    output logic           m2_wbd_bry
);

    localparam int SW = DW / 8;

    arb_state_e     state_q;
    arb_state_e     state_d;
    logic           last_gnt_q;
    logic [BLW-1:0] bl_lat_q;
    logic [BLW-1:0] beat_cnt_q;
    logic [1:0]     req;
    logic [1:0]     pick;
    logic           burst_end;

    logic           mux_cyc;
    logic           mux_stb;
    logic           mux_we;
    logic [AW-1:0]  mux_adr;
    logic [DW-1:0]  mux_dat;
    logic [SW-1:0]  mux_sel;
    logic [BLW-1:0] mux_bl;

    assign req = {m1.cyc & m1.stb, m0.cyc & m0.stb};

    m2_wb_arbiter_rr_arb2 u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .rr_en    (RR_EN),
        .gnt      (pick)
    );

    assign burst_end = m2_wbd.err |
                       (m2_wbd.ack & (m2_wbd.lack | (beat_cnt_q == bl_lat_q - BLW'(1))));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cyc is taken straight from the granted master so an abort reaches the slave at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick[0]) begin
                    state_d = ARB_GNT0;
                end else if (pick[1]) begin
                    state_d = ARB_GNT1;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!mux_cyc || burst_end) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
            bl_lat_q   <= '0;
            beat_cnt_q <= '0;
        end else if (state_q == ARB_IDLE) begin
            beat_cnt_q <= '0;
            if (pick[0]) begin
                bl_lat_q <= (m0.bl == '0) ? BLW'(1) : m0.bl;
            end else if (pick[1]) begin
                bl_lat_q <= (m1.bl == '0) ? BLW'(1) : m1.bl;
            end
        end else begin
            if (m2_wbd.ack) begin
                beat_cnt_q <= beat_cnt_q + BLW'(1);
            end
            if (state_d == ARB_IDLE) begin
                last_gnt_q <= (state_q == ARB_GNT1);
            end
        end
    end

    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        mux_bl  = '0;
        m0.ack  = 1'b0;
        m0.lack = 1'b0;
        m0.err  = 1'b0;
        m1.ack  = 1'b0;
        m1.lack = 1'b0;
        m1.err  = 1'b0;
        case (state_q)
            ARB_GNT0: begin
                mux_cyc = m0.cyc;
                mux_stb = m0.stb;
                mux_we  = m0.we;
                mux_adr = m0.adr;
                mux_dat = m0.dat_w;
                mux_sel = m0.sel;
                mux_bl  = bl_lat_q;
                m0.ack  = m2_wbd.ack;
                m0.lack = m2_wbd.lack;
                m0.err  = m2_wbd.err;
            end
            ARB_GNT1: begin
                mux_cyc = m1.cyc;
                mux_stb = m1.stb;
                mux_we  = m1.we;
                mux_adr = m1.adr;
                mux_dat = m1.dat_w;
                mux_sel = m1.sel;
                mux_bl  = bl_lat_q;
                m1.ack  = m2_wbd.ack;
                m1.lack = m2_wbd.lack;
                m1.err  = m2_wbd.err;
            end
            default: ;
        endcase
    end

    assign m2_wbd.cyc   = mux_cyc;
    assign m2_wbd.stb   = mux_stb;
    assign m2_wbd.we    = mux_we;
    assign m2_wbd.adr   = mux_adr;
    assign m2_wbd.dat_w = mux_dat;
    assign m2_wbd.sel   = mux_sel;
    assign m2_wbd.bl    = mux_bl;
    assign m2_wbd_bry   = mux_stb;

    assign m0.dat_r = m2_wbd.dat_r;
    assign m1.dat_r = m2_wbd.dat_r;

endmodule

// File: tb/tb_m2_wb_arbiter.sv
// Directed bench for m2_wb_arbiter: per-cycle vector table plus burst, error, abort and reset sequences.
module tb_m2_wb_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BLW = 10;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;
    localparam logic [31:0] D0 = 32'hA5A5_0001;
    localparam logic [31:0] D1 = 32'h5A5A_0002;
    localparam logic [31:0] RD = 32'hCAFE_F00D;
    localparam logic [3:0]  S0 = 4'hF;
    localparam logic [3:0]  S1 = 4'h3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic m2_wbd_bry;
    int   checks = 0;
    int   failures = 0;
    int   n_ack;

    m2_wb_arbiter_if #(.AW(AW), .DW(DW), .BLW(BLW)) m0 ();
    m2_wb_arbiter_if #(.AW(AW), .DW(DW), .BLW(BLW)) m1 ();
    m2_wb_arbiter_if #(.AW(AW), .DW(DW), .BLW(BLW)) m2_wbd ();

    m2_wb_arbiter #(.AW(AW), .DW(DW), .BLW(BLW), .RR_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0         (m0),
        .m1         (m1),
        .m2_wbd     (m2_wbd),
        .m2_wbd_bry (m2_wbd_bry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           r0;
        logic           r1;
        logic           ack;
        logic           lack;
        logic           err;
        int             g;
        logic [BLW-1:0] bl;
        logic           a0;
        logic           a1;
        logic           e0;
        logic           e1;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int n, input logic req, input logic [BLW-1:0] bl);
        if (n == 0) begin
            m0.cyc = req;
            m0.stb = req;
            m0.bl  = bl;
        end else begin
            m1.cyc = req;
            m1.stb = req;
            m1.bl  = bl;
        end
    endtask

    task automatic drive_s(input logic ack, input logic lack, input logic err);
        m2_wbd.ack  = ack;
        m2_wbd.lack = lack;
        m2_wbd.err  = err;
    endtask

    // g: 0 = no grant (bus all zero), 1 = M0 routed, 2 = M1 routed
    task automatic chk_bus(input string t, input int g, input logic [BLW-1:0] bl);
        logic        ev;
        logic        ew;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        ev = (g != 0);
        ew = (g == 1);
        ea = (g == 1) ? A0 : (g == 2) ? A1 : 32'h0;
        ed = (g == 1) ? D0 : (g == 2) ? D1 : 32'h0;
        es = (g == 1) ? S0 : (g == 2) ? S1 : 4'h0;
        chk({t, "_cyc"}, m2_wbd.cyc, ev);
        chk({t, "_stb"}, m2_wbd.stb, ev);
        chk({t, "_bry"}, m2_wbd_bry, ev);
        chk({t, "_we"},  m2_wbd.we, ew);
        chk({t, "_adr"}, m2_wbd.adr, ea);
        chk({t, "_dat"}, m2_wbd.dat_w, ed);
        chk({t, "_sel"}, m2_wbd.sel, es);
        chk({t, "_bl"},  m2_wbd.bl, bl);
        chk({t, "_rd0"}, m0.dat_r, RD);
        chk({t, "_rd1"}, m1.dat_r, RD);
    endtask

    task automatic chk_resp(input string t, input logic a0, input logic a1, input logic e0,
                            input logic e1, input logic l0, input logic l1);
        chk({t, "_ack0"},  m0.ack, a0);
        chk({t, "_ack1"},  m1.ack, a1);
        chk({t, "_err0"},  m0.err, e0);
        chk({t, "_err1"},  m1.err, e1);
        chk({t, "_lack0"}, m0.lack, l0);
        chk({t, "_lack1"}, m1.lack, l1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // M0: write, bl=1; M1: read, bl=0 (must be latched as 1)
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2, 10'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        m0.we = 1'b1; m0.adr = A0; m0.dat_w = D0; m0.sel = S0;
        m1.we = 1'b0; m1.adr = A1; m1.dat_w = D1; m1.sel = S1;
        m2_wbd.dat_r = RD;
        drive_m(0, 1'b0, 10'd1);
        drive_m(1, 1'b0, 10'd0);
        drive_s(1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        @(negedge clk);
        chk_bus("rst", 0, 10'd0);
        chk_resp("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive_m(0, tbl[i].r0, 10'd1);
            drive_m(1, tbl[i].r1, 10'd0);
            drive_s(tbl[i].ack, tbl[i].lack, tbl[i].err);
            @(negedge clk);
            chk_bus($sformatf("v%0d", i), tbl[i].g, tbl[i].bl);
            chk_resp($sformatf("v%0d", i), tbl[i].a0, tbl[i].a1, tbl[i].e0, tbl[i].e1,
                     tbl[i].lack && (tbl[i].g == 1), tbl[i].lack && (tbl[i].g == 2));
            tick();
        end

        // M1 bl=8 burst without lack while M0 waits; M0 was served last so M1 wins
        drive_m(0, 1'b1, 10'd1);
        drive_m(1, 1'b1, 10'd8);
        drive_s(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_bus("t3_idle", 0, 10'd0);
        tick();
        n_ack = 0;
        for (int b = 0; b < 8; b++) begin
            drive_s(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk_bus($sformatf("t3_b%0d", b), 2, 10'd8);
            chk($sformatf("t3_b%0d_ack0", b), m0.ack, 1'b0);
            if (m1.ack) n_ack++;
            tick();
        end
        chk("t3_acks", n_ack, 8);
        drive_m(1, 1'b0, 10'd8);
        drive_s(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_bus("t3_rel", 0, 10'd0);
        tick();
        drive_s(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_bus("t3_m0", 1, 10'd1);
        chk_resp("t3_m0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_m(0, 1'b0, 10'd1);
        drive_s(1'b0, 1'b0, 1'b0);

        // M1 bl=4, error on beat 2, then a stray ack in IDLE
        drive_m(1, 1'b1, 10'd4);
        @(negedge clk);
        chk_bus("t4_idle", 0, 10'd0);
        tick();
        drive_s(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_resp("t4_b1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_s(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_bus("t4_b2", 2, 10'd4);
        chk_resp("t4_b2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_m(1, 1'b0, 10'd4);
        drive_s(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_bus("t4_stray", 0, 10'd0);
        chk_resp("t4_stray", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_s(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_bus("t4_stay", 0, 10'd0);
        tick();

        // M0 bl=4 aborts after one beat; pending M1 granted afterwards
        drive_m(0, 1'b1, 10'd4);
        drive_m(1, 1'b1, 10'd0);
        @(negedge clk);
        chk_bus("t5_idle", 0, 10'd0);
        tick();
        drive_s(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_bus("t5_b1", 1, 10'd4);
        chk_resp("t5_b1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive_m(0, 1'b0, 10'd4);
        drive_s(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_abort_cyc", m2_wbd.cyc, 1'b0);
        chk("t5_abort_stb", m2_wbd.stb, 1'b0);
        tick();
        @(negedge clk);
        chk_bus("t5_gap", 0, 10'd0);
        tick();
        drive_s(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_bus("t5_m1", 2, 10'd1);
        chk_resp("t5_m1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive_m(1, 1'b0, 10'd0);
        drive_s(1'b0, 1'b0, 1'b0);

        // M0 single leaves last_gnt=M0, then reset lands mid M1 burst
        drive_m(0, 1'b1, 10'd1);
        tick();
        drive_s(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_resp("t6_m0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_m(0, 1'b0, 10'd1);
        drive_m(1, 1'b1, 10'd8);
        drive_s(1'b0, 1'b0, 1'b0);
        tick();
        for (int b = 0; b < 2; b++) begin
            drive_s(1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("t6_b%0d_ack1", b), m1.ack, 1'b1);
            tick();
        end
        drive_s(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk_bus("t6_b2", 2, 10'd8);
        tick();
        @(negedge clk);
        chk_bus("t6_rst", 0, 10'd0);
        chk_resp("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive_m(0, 1'b1, 10'd1);
        drive_s(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_bus("t6_idle", 0, 10'd0);
        tick();
        @(negedge clk);
        chk_bus("t6_rr", 1, 10'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
